crypt_uart_tx: RTL and testbench



---
 rtl/crypt_uart_tx_if.sv | 11 +
 rtl/crypt_uart_tx.sv | 116 +++++++++++
 tb/tb_crypt_uart_tx.sv | 158 +++++++++++++++
 3 files changed

// File: rtl/crypt_uart_tx_if.sv
// crypt_uart_tx_if: encryptor-to-serializer strobe/data and serial-side status signals.
interface crypt_uart_tx_if;
  logic       cy_status;
  logic [7:0] cy_data;
  logic       tx;
  logic       busy;
  logic       fifo_full;
  logic       overflow;
  modport master (output cy_status, cy_data, input tx, busy, fifo_full, overflow);
  modport slave  (input cy_status, cy_data, output tx, busy, fifo_full, overflow);
endinterface

// File: rtl/crypt_uart_tx.sv
// crypt_uart_tx: buffers ciphertext bytes in a FIFO and serializes them as 8N1 frames.
// Define CRYPT_TX_PARITY_EN to insert an even-parity bit between data and stop.
module crypt_uart_tx #(
  parameter int CLKS_PER_BIT = 868,
  parameter int FIFO_DEPTH   = 4
) (
  input logic             clk,
  input logic             rst_n,
  crypt_uart_tx_if.slave  bus
);
  localparam int AW = $clog2(FIFO_DEPTH);
  localparam int CW = $clog2(CLKS_PER_BIT);
`ifdef CRYPT_TX_PARITY_EN
  typedef enum logic [2:0] {IDLE, START, DATA, PARITY, STOP} state_t;
  localparam state_t AFTER_DATA = PARITY;
`else
  typedef enum logic [2:0] {IDLE, START, DATA, STOP} state_t;
  localparam state_t AFTER_DATA = STOP;
`endif
  state_t        state_q, state_d;
  logic [CW-1:0] baud_q, baud_d;
  logic [2:0]    bit_q, bit_d;
  logic [7:0]    shift_q, shift_d;
  logic [7:0]    mem [FIFO_DEPTH];
  logic [AW-1:0] wr_ptr, rd_ptr;
  logic [AW:0]   count_q, count_d;
  logic          fifo_full_q, overflow_q, busy_q, tx_q, tx_d, busy_d;
  logic          push, pop, wrap;
`ifdef CRYPT_TX_PARITY_EN
  logic          par_q, par_d;
`endif
  assign wrap = baud_q == CW'(CLKS_PER_BIT - 1);
  // Fullness comes from the registered flag, so a same-edge pop never admits a write.
  assign push = bus.cy_status & ~fifo_full_q;
  always_comb begin
    pop     = 1'b0;
    state_d = state_q;
    baud_d  = wrap ? '0 : baud_q + 1'b1;
    bit_d   = bit_q;
    shift_d = shift_q;
    case (state_q)
      IDLE: begin
        baud_d = '0;
        if (count_q != '0) begin
          pop     = 1'b1;
          state_d = START;
        end
      end
      START: if (wrap) begin
        state_d = DATA;
        bit_d   = '0;
      end
      DATA: if (wrap) begin
        shift_d = shift_q >> 1;
        bit_d   = bit_q + 3'd1;
        if (bit_q == 3'd7) state_d = AFTER_DATA;
      end
`ifdef CRYPT_TX_PARITY_EN
      PARITY: if (wrap) state_d = STOP;
`endif
      STOP: if (wrap) begin
        pop     = count_q != '0;
        state_d = pop ? START : IDLE;
      end
      default: state_d = IDLE;
    endcase
    shift_d = pop ? mem[rd_ptr] : shift_d;
    count_d = count_q + (AW+1)'(push) - (AW+1)'(pop);
    busy_d  = (state_d != IDLE) | (count_d != '0);
    tx_d    = state_d == START ? 1'b0 : state_d == DATA ? shift_d[0] : 1'b1;
`ifdef CRYPT_TX_PARITY_EN
    par_d   = pop ? ^mem[rd_ptr] : par_q;
    tx_d    = state_d == PARITY ? par_q : tx_d;
`endif
  end
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= IDLE;
      baud_q      <= '0;
      bit_q       <= '0;
      shift_q     <= '0;
      wr_ptr      <= '0;
      rd_ptr      <= '0;
      count_q     <= '0;
      fifo_full_q <= 1'b0;
      overflow_q  <= 1'b0;
      busy_q      <= 1'b0;
      tx_q        <= 1'b1;
    end else begin
      state_q     <= state_d;
      baud_q      <= baud_d;
      bit_q       <= bit_d;
      shift_q     <= shift_d;
      wr_ptr      <= wr_ptr + AW'(push);
      rd_ptr      <= rd_ptr + AW'(pop);
      count_q     <= count_d;
      fifo_full_q <= count_d == (AW+1)'(FIFO_DEPTH);
      overflow_q  <= bus.cy_status & fifo_full_q;
      busy_q      <= busy_d;
      tx_q        <= tx_d;
    end
  end
`ifdef CRYPT_TX_PARITY_EN
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) par_q <= 1'b0;
    else        par_q <= par_d;
  end
`endif
  always_ff @(posedge clk) begin
    if (push) mem[wr_ptr] <= bus.cy_data;
  end
  assign bus.tx        = tx_q;
  assign bus.busy      = busy_q;
  assign bus.fifo_full = fifo_full_q;
  assign bus.overflow  = overflow_q;
endmodule

// File: tb/tb_crypt_uart_tx.sv
// tb_crypt_uart_tx: vector table, directed corner sequences and random traffic vs a frame-schedule model.
module tb_crypt_uart_tx;
`ifdef CRYPT_TX_PARITY_EN
  localparam int FL = 44;
  localparam bit PAR = 1'b1;
`else
  localparam int FL = 40;
  localparam bit PAR = 1'b0;
`endif
  logic clk = 1'b0;
  logic rst_n = 1'b0;
  int n_chk = 0;
  int n_fail = 0;
  int cyc = 0;
  bit ov_exp = 1'b0;
  int acc_q[$];
  int st_q[$];
  logic [7:0] dat_q[$];
  crypt_uart_tx_if bus();
  crypt_uart_tx #(.CLKS_PER_BIT(4), .FIFO_DEPTH(4)) dut (.clk(clk), .rst_n(rst_n), .bus(bus));
  always #5 clk = ~clk;
  typedef struct { logic [7:0] d; logic [7:0] seq; logic par; } vec_t;
  vec_t tbl[5];
  task automatic chk(input string name, input logic act, input logic exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s cyc=%0d got=%b exp=%b", name, cyc, act, exp);
    end
  endtask
  // FIFO occupancy after edge t: accepted by t, not yet popped into a frame.
  function automatic int cnt_at(input int t);
    int n = 0;
    foreach (acc_q[i]) if (acc_q[i] <= t && st_q[i] > t) n++;
    return n;
  endfunction
  function automatic logic exp_tx(input int t);
    foreach (st_q[i]) if (t >= st_q[i] && t < st_q[i] + FL) begin
      int k = (t - st_q[i]) / 4;
      if (k == 0) return 1'b0;
      if (k <= 8) return dat_q[i][k-1];
      if (PAR && k == 9) return ^dat_q[i];
      return 1'b1;
    end
    return 1'b1;
  endfunction
  function automatic logic exp_busy(input int t);
    foreach (st_q[i]) if (acc_q[i] <= t && t < st_q[i] + FL) return 1'b1;
    return 1'b0;
  endfunction
  task automatic model_edge(input bit s, input logic [7:0] d);
    bit full = cnt_at(cyc - 1) == 4;
    int st = cyc + 1;
    ov_exp = s && full;
    if (s && !full) begin
      if (st_q.size() > 0 && st_q[st_q.size()-1] + FL > st) st = st_q[st_q.size()-1] + FL;
      acc_q.push_back(cyc);
      st_q.push_back(st);
      dat_q.push_back(d);
    end
  endtask
  task automatic step(input bit s, input logic [7:0] d);
    bus.cy_status = s;
    bus.cy_data   = d;
    @(posedge clk);
    cyc++;
    model_edge(s, d);
    @(negedge clk);
    chk("tx", bus.tx, exp_tx(cyc));
    chk("busy", bus.busy, exp_busy(cyc));
    chk("fifo_full", bus.fifo_full, cnt_at(cyc) == 4);
    chk("overflow", bus.overflow, ov_exp);
    bus.cy_status = 1'b0;
  endtask
  task automatic do_reset();
    rst_n = 1'b0;
    #1;
    chk("rst_tx", bus.tx, 1'b1);
    chk("rst_busy", bus.busy, 1'b0);
    chk("rst_full", bus.fifo_full, 1'b0);
    chk("rst_ovf", bus.overflow, 1'b0);
    acc_q.delete();
    st_q.delete();
    dat_q.delete();
    ov_exp = 1'b0;
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
  endtask
  initial begin
    int e, t, ovc, fulls, rate;
    logic expb;
    tbl[0] = '{8'hA5, 8'b10100101, 1'b0};
    tbl[1] = '{8'h07, 8'b11100000, 1'b1};
    tbl[2] = '{8'h12, 8'b01001000, 1'b0};
    tbl[3] = '{8'h80, 8'b00000001, 1'b1};
    tbl[4] = '{8'hFF, 8'b11111111, 1'b0};
    bus.cy_status = 1'b0;
    bus.cy_data   = 8'h00;
    repeat (2) @(negedge clk);
    do_reset();
    repeat (100) step(1'b0, 8'h00);
    for (int i = 0; i < 5; i++) begin
      step(1'b1, tbl[i].d);
      e = cyc;
      while (cyc < e + FL + 1) begin
        step(1'b0, 8'h00);
        t = cyc - e - 1;
        if (t >= 0 && t % 4 == 2) begin
          expb = t / 4 == 0 ? 1'b0 : t / 4 <= 8 ? tbl[i].seq[8 - t / 4] :
                 (PAR && t / 4 == 9) ? tbl[i].par : 1'b1;
          chk("vec_slot", bus.tx, expb);
        end
        if (cyc == e + FL) chk("vec_busy_hold", bus.busy, 1'b1);
        if (cyc == e + FL + 1) chk("vec_busy_fall", bus.busy, 1'b0);
      end
      repeat (3) step(1'b0, 8'h00);
    end
    ovc = 0;
    fulls = 0;
    for (int i = 1; i <= 6; i++) begin
      step(1'b1, 8'(i));
      ovc += int'(bus.overflow);
      repeat (3) begin
        step(1'b0, 8'h00);
        ovc += int'(bus.overflow);
        fulls += int'(bus.fifo_full);
      end
    end
    chk("burst_ovf_once", ovc == 1, 1'b1);
    chk("burst_full_seen", fulls > 0, 1'b1);
    repeat (6 * FL) step(1'b0, 8'h00);
    step(1'b1, 8'hC3);
    e = cyc;
    for (int i = 0; i < 4; i++) step(1'b1, 8'(8'h50 + i));
    chk("bnd_full", bus.fifo_full, 1'b1);
    while (cyc < e + FL) step(1'b0, 8'h00);
    step(1'b1, 8'hEE);
    chk("bnd_ovf", bus.overflow, 1'b1);
    chk("bnd_not_full", bus.fifo_full, 1'b0);
    repeat (5 * FL) step(1'b0, 8'h00);
    step(1'b1, 8'hA5);
    e = cyc;
    step(1'b1, 8'h11);
    step(1'b1, 8'h22);
    while (cyc < e + 1 + 17) step(1'b0, 8'h00);
    chk("mid_bit3_low", bus.tx, 1'b0);
    #2;
    do_reset();
    repeat (60) step(1'b0, 8'h00);
    for (int blk = 0; blk < 8; blk++) begin
      rate = blk % 3 == 0 ? 2 : blk % 3 == 1 ? 8 : 40;
      repeat (200) step($urandom_range(0, 99) < rate, 8'($urandom));
    end
    repeat (6 * FL) step(1'b0, 8'h00);
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule
